// File: rtl/fifo_cmd_conditioner_pkg.sv
// fifo_cmd_conditioner_pkg: shared widths, debounce default and saturating drop-counter helper
package fifo_cmd_conditioner_pkg;
  localparam int DATA_WIDTH = 8;
  localparam int DEBOUNCE_CYCLES = 4;
  localparam int DROP_CNT_WIDTH = 8;
  localparam logic [DROP_CNT_WIDTH-1:0] DROP_CNT_MAX = '1;
  function automatic logic [DROP_CNT_WIDTH-1:0] sat_add(input logic [DROP_CNT_WIDTH-1:0] cnt, input logic [1:0] inc);
    logic [DROP_CNT_WIDTH:0] sum;
    sum = {1'b0, cnt} + {{(DROP_CNT_WIDTH-1){1'b0}}, inc};
    return sum > {1'b0, DROP_CNT_MAX} ? DROP_CNT_MAX : sum[DROP_CNT_WIDTH-1:0];
  endfunction
endpackage

// File: rtl/fifo_cmd_conditioner_btn_debounce.sv
// btn_debounce: synchronizes a raw button, filters bounce and emits a one-cycle press pulse
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = fifo_cmd_conditioner_pkg::DEBOUNCE_CYCLES,
  parameter int CNT_WIDTH = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic press
);
  logic s1, s2, stable, stable_d;
  logic [CNT_WIDTH-1:0] cnt;
  // two-flop synchronizer, then accept a level only after it has held for DEBOUNCE_CYCLES
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      stable <= 1'b0;
      stable_d <= 1'b0;
      cnt <= '0;
    end else begin
      s1 <= btn_raw;
      s2 <= s1;
      stable_d <= stable;
      if (s2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_WIDTH'(DEBOUNCE_CYCLES - 1)) begin
        stable <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_WIDTH'(1);
      end
    end
  end
  assign press = stable & ~stable_d;
endmodule

// File: rtl/fifo_cmd_conditioner.sv
// fifo_cmd_conditioner: turns debounced button presses into gated FIFO wr/rd strobes and counts rejects
module fifo_cmd_conditioner
  import fifo_cmd_conditioner_pkg::*;
#(
  parameter int DATA_WIDTH = fifo_cmd_conditioner_pkg::DATA_WIDTH,
  parameter int DEBOUNCE_CYCLES = fifo_cmd_conditioner_pkg::DEBOUNCE_CYCLES,
  parameter int CNT_WIDTH = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      btn_wr,
  input  logic                      btn_rd,
  input  logic [DATA_WIDTH-1:0]     sw_data,
  input  logic                      fifo_full,
  input  logic                      fifo_empty,
  output logic                      wr,
  output logic                      rd,
  output logic [DATA_WIDTH-1:0]     data_out,
  output logic                      wr_drop,
  output logic                      rd_drop,
  output logic [DROP_CNT_WIDTH-1:0] drop_count
);
  logic wr_press, rd_press, wr_ok, rd_ok, wr_rej, rd_rej;
  logic [1:0] drop_inc;
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_WIDTH(CNT_WIDTH)) u_wr (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_wr), .press(wr_press)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_WIDTH(CNT_WIDTH)) u_rd (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_rd), .press(rd_press)
  );
  assign wr_ok = wr_press & ~fifo_full;
  assign rd_ok = rd_press & ~fifo_empty;
  assign wr_rej = wr_press & fifo_full;
  assign rd_rej = rd_press & fifo_empty;
  assign drop_inc = {1'b0, wr_rej} + {1'b0, rd_rej};
  // register strobes and drop pulses; capture data only on an accepted write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr <= 1'b0;
      rd <= 1'b0;
      wr_drop <= 1'b0;
      rd_drop <= 1'b0;
      data_out <= '0;
      drop_count <= '0;
    end else begin
      wr <= wr_ok;
      rd <= rd_ok;
      wr_drop <= wr_rej;
      rd_drop <= rd_rej;
      data_out <= wr_ok ? sw_data : data_out;
      drop_count <= sat_add(drop_count, drop_inc);
    end
  end
endmodule
